// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if -- control bundle between the multi-cycle sequencer and its datapath/memory.
//   opcode   : instr[6:0] from the instruction register
//   mem_ack  : memory completion
//   halt_req : stop request
//   ir_we, pc_we, rf_we : datapath strobes
//   mem_req, mem_we     : memory request and write qualifier
//   state    : current sequencer state encoding
//   busy     : instruction in flight
//   fault    : sticky memory-timeout flag
// The master modport is the sequencer; the slave modport is the datapath/memory side.
interface mc_sequencer_if;
   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned STATE_W  = 3;

   logic [OPCODE_W-1:0] opcode;
   logic                mem_ack;
   logic                halt_req;
   logic                ir_we;
   logic                pc_we;
   logic                rf_we;
   logic                mem_req;
   logic                mem_we;
   logic [STATE_W-1:0]  state;
   logic                busy;
   logic                fault;

   modport master (
      input  opcode, mem_ack, halt_req,
      output ir_we, pc_we, rf_we, mem_req, mem_we, state, busy, fault
   );

   modport slave (
      output opcode, mem_ack, halt_req,
      input  ir_we, pc_we, rf_we, mem_req, mem_we, state, busy, fault
   );
endinterface

// File: rtl/mc_sequencer.sv
// mc_sequencer -- multi-cycle instruction sequencer:
//   IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH / HALT.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mc_sequencer_if.master (opcode, mem_ack, halt_req in;
//           ir_we, pc_we, rf_we, mem_req, mem_we, state, busy, fault out)
// Parameter TIMEOUT: memory-wait cycle limit, used only with the optional timeout.
// Optional feature: define MC_SEQ_TIMEOUT_EN to enable the memory-wait timeout
// counter and the FAULT state; without it waits are unbounded and fault stays 0.
// ir_we is a Mealy output (FETCH and mem_ack); every other output is a flop
// loaded from the next state, so it always reflects the registered state.
module mc_sequencer #(
   parameter int unsigned TIMEOUT = 15
) (
   input logic            clk,
   input logic            rst_n,
   mc_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_FAULT  = 3'd7
   } state_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   state_e state_q, state_d;
   logic   ir_we_c;
   logic   pc_we_q,   pc_we_d;
   logic   rf_we_q,   rf_we_d;
   logic   mem_req_q, mem_req_d;
   logic   mem_we_q,  mem_we_d;
   logic   busy_q,    busy_d;
   logic   fault_q,   fault_d;
   logic   is_mem_op;
   logic   writes_rf;
   logic   wait_expired;

   // Opcode classification: memory access and register-file writers.
   always_comb begin
      is_mem_op = (bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE);
      writes_rf = 1'b0;
      case (bus.opcode)
         OP_RTYPE, OP_ITYPE, OP_LOAD, OP_JAL,
         OP_JALR, OP_LUI, OP_AUIPC: writes_rf = 1'b1;
         default:                   writes_rf = 1'b0;
      endcase
   end

`ifdef MC_SEQ_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // This wait cycle is the TIMEOUT-th one without an ack.
   always_comb wait_expired = ((32'(cnt_q) + 32'd1) >= TIMEOUT);

   // Wait counter: clears on entry to FETCH/MEM, counts unacknowledged request cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q)) begin
         cnt_d = '0;
      end else if (mem_req_q && !bus.mem_ack && !wait_expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   logic unused_timeout;

   always_comb wait_expired = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   // Next-state logic and the Mealy instruction-register strobe.
   always_comb begin
      state_d = state_q;
      ir_we_c = 1'b0;
      case (state_q)
         S_IDLE:   state_d = bus.halt_req ? S_HALT : S_FETCH;
         S_FETCH: begin
            if (bus.mem_ack) begin
               ir_we_c = 1'b1;
               state_d = S_DECODE;
            end else if (wait_expired) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = is_mem_op ? S_MEM : S_WB;
         S_MEM: begin
            if (bus.mem_ack)       state_d = S_WB;
            else if (wait_expired) state_d = S_FAULT;
         end
         S_WB:     state_d = bus.halt_req ? S_HALT : S_FETCH;
         S_HALT:   state_d = bus.halt_req ? S_HALT : S_FETCH;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the state about to be registered.
   always_comb begin
      mem_req_d = (state_d == S_FETCH) || (state_d == S_MEM);
      mem_we_d  = (state_d == S_MEM) && (bus.opcode == OP_STORE);
      pc_we_d   = (state_d == S_WB);
      rf_we_d   = (state_d == S_WB) && writes_rf;
      busy_d    = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC) ||
                  (state_d == S_MEM)   || (state_d == S_WB);
`ifdef MC_SEQ_TIMEOUT_EN
      fault_d   = fault_q || (state_d == S_FAULT);
`else
      fault_d   = 1'b0;
`endif
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_we_q   <= 1'b0;
         rf_we_q   <= 1'b0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         busy_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_we_q   <= pc_we_d;
         rf_we_q   <= rf_we_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         busy_q    <= busy_d;
         fault_q   <= fault_d;
      end
   end

   assign bus.state   = state_q;
   assign bus.ir_we   = ir_we_c;
   assign bus.pc_we   = pc_we_q;
   assign bus.rf_we   = rf_we_q;
   assign bus.mem_req = mem_req_q;
   assign bus.mem_we  = mem_we_q;
   assign bus.busy    = busy_q;
   assign bus.fault   = fault_q;
endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer -- self-checking bench for mc_sequencer.
// Each instruction is described by opcode, fetch wait, memory wait and halt;
// the bench expands that into the expected per-cycle output trace, and a
// compare process checks the DUT against it on every falling clock edge.
module tb_mc_sequencer;
   localparam int unsigned TB_TIMEOUT = 4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ADD    = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   typedef struct {
      logic [2:0] st;
      logic ir, pc, rf, mr, mw, bz, fl;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   mc_sequencer_if bus();

   mc_sequencer #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   logic exp_fault = 1'b0;
   int   obs_ir, obs_pc, obs_rf, obs_mw;
   int   trace[$];

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, want);
      end
   endtask

   // Spec rule: these opcodes write the register file in WB.
   function automatic logic writes_rf(input logic [6:0] op);
      logic [6:0] wr_ops [7];
      wr_ops = '{OP_ADD, OP_ADDI, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      writes_rf = 1'b0;
      for (int i = 0; i < 7; i++) if (wr_ops[i] == op) writes_rf = 1'b1;
   endfunction

   task automatic push(input logic [2:0] st, input logic ir, input logic pc, input logic rf,
                       input logic mr, input logic mw, input logic bz);
      exp_t e;
      e.st = st; e.ir = ir; e.pc = pc; e.rf = rf;
      e.mr = mr; e.mw = mw; e.bz = bz; e.fl = exp_fault;
      exp_q.push_back(e);
   endtask

   // One clock cycle: drive this cycle's inputs just after the rising edge.
   task automatic cyc(input logic [6:0] op, input logic ack, input logic halt);
      @(posedge clk);
      #1;
      bus.opcode   = op;
      bus.mem_ack  = ack;
      bus.halt_req = halt;
   endtask

   // Expected trace of one instruction, starting in FETCH.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit hx);
      bit mem_op;
      bit wr;
      mem_op = (op == OP_LOAD) || (op == OP_STORE);
      wr     = writes_rf(op);
      for (int i = 0; i <= fw; i++) begin
         cyc(~op, (i == fw), 1'b0);
         push(3'd1, (i == fw), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      cyc(op, 1'b0, 1'b0); push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(op, 1'b0, hx);   push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (mem_op) begin
         for (int i = 0; i <= mw; i++) begin
            cyc(op, (i == mw), hx);
            push(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, (op == OP_STORE), 1'b1);
         end
      end
      cyc(op, 1'b0, hx); push(3'd5, 1'b0, 1'b1, wr, 1'b0, 1'b0, 1'b1);
   endtask

   // n cycles in HALT with halt_req held, then one release cycle.
   task automatic hold_halt(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(7'd0, 1'b0, 1'b1); push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      cyc(7'd0, 1'b0, 1'b0); push(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic clear_obs();
      obs_ir = 0; obs_pc = 0; obs_rf = 0; obs_mw = 0;
      trace.delete();
   endtask

   task automatic chk_trace(input string name, input int want[$]);
      chk({name, "_len"}, trace.size(), want.size());
      for (int i = 0; i < want.size() && i < trace.size(); i++)
         chk($sformatf("%s[%0d]", name, i), trace[i], want[i]);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_state"},   int'(bus.state),   0);
      chk({tag, "_mem_req"}, int'(bus.mem_req), 0);
      chk({tag, "_mem_we"},  int'(bus.mem_we),  0);
      chk({tag, "_ir_we"},   int'(bus.ir_we),   0);
      chk({tag, "_pc_we"},   int'(bus.pc_we),   0);
      chk({tag, "_rf_we"},   int'(bus.rf_we),   0);
      chk({tag, "_busy"},    int'(bus.busy),    0);
      chk({tag, "_fault"},   int'(bus.fault),   0);
   endtask

   // Per-cycle comparison against the expected trace.
   always @(negedge clk) begin : compare
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("state",   int'(bus.state),   int'(e.st));
         chk("ir_we",   int'(bus.ir_we),   int'(e.ir));
         chk("pc_we",   int'(bus.pc_we),   int'(e.pc));
         chk("rf_we",   int'(bus.rf_we),   int'(e.rf));
         chk("mem_req", int'(bus.mem_req), int'(e.mr));
         chk("mem_we",  int'(bus.mem_we),  int'(e.mw));
         chk("busy",    int'(bus.busy),    int'(e.bz));
         chk("fault",   int'(bus.fault),   int'(e.fl));
         trace.push_back(int'(bus.state));
         obs_ir += int'(bus.ir_we);
         obs_pc += int'(bus.pc_we);
         obs_rf += int'(bus.rf_we);
         obs_mw += int'(bus.mem_we);
      end
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not finish, got running, want done");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [6:0] ops [6];
      int         want[$];
      ops = '{OP_ADDI, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_BRANCH};

      rst_n = 1'b0; bus.opcode = '0; bus.mem_ack = 1'b0; bus.halt_req = 1'b0;
      clear_obs();
      #2;
      chk_reset_outputs("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_after_release", int'(bus.state), 0);

      // ADD, fetch acked one cycle after the request.
      clear_obs();
      run_instr(OP_ADD, 1, 0, 1'b0);
      @(negedge clk); #1;
      want = '{1, 1, 2, 3, 5};
      chk_trace("add_trace", want);
      chk("add_ir_pulses", obs_ir, 1);
      chk("add_pc_pulses", obs_pc, 1);
      chk("add_rf_pulses", obs_rf, 1);

      // Store acknowledged on the third MEM cycle.
      clear_obs();
      run_instr(OP_STORE, 0, 2, 1'b0);
      @(negedge clk); #1;
      chk("store_mem_we_cycles", obs_mw, 3);
      chk("store_rf_pulses", obs_rf, 0);
      chk("store_pc_pulses", obs_pc, 1);

      // Load with halt raised during EXEC: completes, halts, then resumes.
      clear_obs();
      run_instr(OP_LOAD, 1, 1, 1'b1);
      hold_halt(2);
      @(negedge clk); #1;
      want = '{1, 1, 2, 3, 4, 4, 5, 6, 6, 6};
      chk_trace("load_halt_trace", want);
      chk("load_rf_pulses", obs_rf, 1);

      // Unknown opcode behaves as a NOP.
      clear_obs();
      run_instr(OP_BAD, 0, 0, 1'b0);
      @(negedge clk); #1;
      want = '{1, 2, 3, 5};
      chk_trace("bad_trace", want);
      chk("bad_rf_pulses", obs_rf, 0);
      chk("bad_pc_pulses", obs_pc, 1);

      for (int i = 0; i < 6; i++) run_instr(ops[i], i % 2, 0, 1'b0);

`ifndef MC_SEQ_TIMEOUT_EN
      // Without the timeout, long waits are simply waited out.
      run_instr(OP_ADD, 20, 0, 1'b0);
      run_instr(OP_LOAD, 0, 12, 1'b0);
`endif

      // Reset pulsed in the middle of a store's MEM phase.
      cyc(~OP_STORE, 1'b1, 1'b0); push(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc(OP_STORE, 1'b0, 1'b0);  push(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(OP_STORE, 1'b0, 1'b0);  push(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(OP_STORE, 1'b0, 1'b0);  push(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      cyc(OP_STORE, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      bus.halt_req = 1'b1;
      #1;
      chk_reset_outputs("mid_mem_reset");
      cyc(7'd0, 1'b1, 1'b1); push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(7'd0, 1'b1, 1'b1); push(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      // halt_req held through release: IDLE goes to HALT.
      hold_halt(1);
      run_instr(OP_ADD, 0, 0, 1'b0);

`ifdef MC_SEQ_TIMEOUT_EN
      // Ack on the TIMEOUT-th wait cycle wins in both FETCH and MEM.
      run_instr(OP_LOAD, TB_TIMEOUT - 1, TB_TIMEOUT - 1, 1'b0);
      // No ack in FETCH: FAULT after TIMEOUT wait cycles, left only by reset.
      for (int i = 0; i < int'(TB_TIMEOUT); i++) begin
         cyc(~OP_ADD, 1'b0, 1'b0); push(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      exp_fault = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(OP_ADD, 1'b1, (i == 1)); push(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk); #1;
      chk("fault_sticky", int'(bus.fault), 1);
      chk("fault_state", int'(bus.state), 7);
      rst_n = 1'b0;
      bus.halt_req = 1'b0;
      bus.mem_ack = 1'b0;
      exp_fault = 1'b0;
      #1;
      chk_reset_outputs("fault_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(OP_ADD, 0, 0, 1'b0);
`endif

      @(negedge clk); #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
